// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch unit and its instruction queue.
package fetch_unit_pkg;

  localparam logic [14:0] RESET_PC_DEFAULT = 15'h0000;
  localparam int          QDEPTH           = 4;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [15:0] instr;
    logic [14:0] pc;
  } q_entry_t;

  // Decode may only consume what is actually presented to it.
  function automatic logic [1:0] min_take(input logic [1:0] take, input logic [1:0] avail);
    return (take < avail) ? take : avail;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// ROM and decode-side signals of the fetch unit. The master side is the fetch unit.
interface fetch_unit_if;

  logic [13:0] Rom_addr_in;
  logic        pc_1;
  logic        sel_mem_1;
  logic [1:0]  sel_mem_0;
  logic [15:0] IR_0;
  logic [15:0] IR_1;
  logic        branch_valid;
  logic [14:0] branch_target;
  logic        halt_req;
  logic [1:0]  dec_take;
  logic [1:0]  dec_count;
  logic [15:0] dec_instr_0;
  logic [15:0] dec_instr_1;
  logic [14:0] dec_pc_0;

  modport master (
    output Rom_addr_in, pc_1, sel_mem_1, sel_mem_0,
    output dec_count, dec_instr_0, dec_instr_1, dec_pc_0,
    input  IR_0, IR_1, branch_valid, branch_target, halt_req, dec_take
  );

  modport slave (
    input  Rom_addr_in, pc_1, sel_mem_1, sel_mem_0,
    input  dec_count, dec_instr_0, dec_instr_1, dec_pc_0,
    output IR_0, IR_1, branch_valid, branch_target, halt_req, dec_take
  );

endinterface

// File: rtl/fetch_queue.sv
// Circular instruction queue: 2-wide push, 0..2-wide pop, registered head outputs.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter logic [14:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = QDEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  q_entry_t    push_entry_0,
  input  q_entry_t    push_entry_1,
  input  logic [1:0]  take,
  output logic [2:0]  occupancy,
  output logic [1:0]  dec_count,
  output logic [15:0] dec_instr_0,
  output logic [15:0] dec_instr_1,
  output logic [14:0] dec_pc_0
);

  localparam int PW = $clog2(DEPTH);

  q_entry_t        mem_r [DEPTH];
  q_entry_t        mem_s [DEPTH];
  logic [PW-1:0]   rd_r, wr_r, rd_s, wr_s, wr_p1_s, rd_p1_s;
  logic [2:0]      occ_r, occ_s;
  logic [1:0]      eff_take_s, dcnt_s;
  logic [1:0]      dec_count_r;
  logic [15:0]     dec_instr_0_r, dec_instr_1_r;
  logic [14:0]     dec_pc_0_r;

  // Next queue contents: flush wins, otherwise pop the taken head and append a fetched pair.
  always_comb begin
    mem_s      = mem_r;
    eff_take_s = min_take(take, dec_count_r);
    wr_p1_s    = wr_r + PW'(1);
    rd_s       = rd_r;
    wr_s       = wr_r;
    occ_s      = occ_r;
    if (flush) begin
      rd_s  = PW'(0);
      wr_s  = PW'(0);
      occ_s = 3'd0;
    end else begin
      rd_s  = rd_r + PW'(eff_take_s);
      occ_s = occ_r - {1'b0, eff_take_s};
      if (push) begin
        mem_s[wr_r]    = push_entry_0;
        mem_s[wr_p1_s] = push_entry_1;
        wr_s           = wr_r + PW'(2);
        occ_s          = occ_s + 3'd2;
      end else begin
        wr_s = wr_r;
      end
    end
    rd_p1_s = rd_s + PW'(1);
    if (occ_s >= 3'd2) begin
      dcnt_s = 2'd2;
    end else begin
      dcnt_s = occ_s[1:0];
    end
  end

  // Queue state and registered decode-facing view of the new head.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      rd_r          <= PW'(0);
      wr_r          <= PW'(0);
      occ_r         <= 3'd0;
      dec_count_r   <= 2'd0;
      dec_instr_0_r <= 16'h0000;
      dec_instr_1_r <= 16'h0000;
      dec_pc_0_r    <= RESET_PC;
    end else begin
      mem_r         <= mem_s;
      rd_r          <= rd_s;
      wr_r          <= wr_s;
      occ_r         <= occ_s;
      dec_count_r   <= dcnt_s;
      dec_instr_0_r <= (dcnt_s != 2'd0) ? mem_s[rd_s].instr : 16'h0000;
      dec_instr_1_r <= (dcnt_s == 2'd2) ? mem_s[rd_p1_s].instr : 16'h0000;
      dec_pc_0_r    <= (dcnt_s != 2'd0) ? mem_s[rd_s].pc : dec_pc_0_r;
    end
  end

  assign occupancy   = occ_r;
  assign dec_count   = dec_count_r;
  assign dec_instr_0 = dec_instr_0_r;
  assign dec_instr_1 = dec_instr_1_r;
  assign dec_pc_0    = dec_pc_0_r;

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: boot/fetch/halt FSM, fetch PC, ROM slot selects and the instruction queue.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [14:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          QDEPTH   = fetch_unit_pkg::QDEPTH
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  fetch_state_e state_r;
  logic [14:0]  pc_r;
  logic [14:0]  pc_p1_s;
  logic [2:0]   occ_s;
  logic         fire_s;
  q_entry_t     entry_0_s, entry_1_s;

  // A fetch needs room for a full pair based on the registered occupancy.
  always_comb begin
    fire_s = 1'b0;
    if ((state_r == ST_FETCH) && !bus.halt_req && !bus.branch_valid && (occ_s <= 3'd2)) begin
      fire_s = 1'b1;
    end else begin
      fire_s = 1'b0;
    end
  end

  assign pc_p1_s   = pc_r + 15'd1;
  assign entry_0_s = '{instr: bus.IR_0, pc: pc_r};
  assign entry_1_s = '{instr: bus.IR_1, pc: pc_p1_s};

  // FSM and fetch PC; reset beats branch, branch beats everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_BOOT;
      pc_r    <= RESET_PC;
    end else if (bus.branch_valid) begin
      state_r <= bus.halt_req ? ST_HALT : ST_FETCH;
      pc_r    <= bus.branch_target;
    end else begin
      case (state_r)
        ST_BOOT:  state_r <= ST_FETCH;
        ST_FETCH: state_r <= bus.halt_req ? ST_HALT : ST_FETCH;
        ST_HALT:  state_r <= bus.halt_req ? ST_HALT : ST_FETCH;
        default:  state_r <= ST_BOOT;
      endcase
      pc_r <= fire_s ? (pc_r + 15'd2) : pc_r;
    end
  end

  // ROM addressing follows the fetch PC register directly.
  assign bus.Rom_addr_in = pc_r[14:1];
  assign bus.pc_1        = pc_r[0];
  assign bus.sel_mem_1   = ~pc_r[0];
  assign bus.sel_mem_0   = pc_r[0] ? 2'd2 : 2'd0;

  fetch_queue #(
    .RESET_PC (RESET_PC),
    .DEPTH    (QDEPTH)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .flush        (bus.branch_valid),
    .push         (fire_s),
    .push_entry_0 (entry_0_s),
    .push_entry_1 (entry_1_s),
    .take         (bus.dec_take),
    .occupancy    (occ_s),
    .dec_count    (bus.dec_count),
    .dec_instr_0  (bus.dec_instr_0),
    .dec_instr_1  (bus.dec_instr_1),
    .dec_pc_0     (bus.dec_pc_0)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic against a queue model.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [15:0] instr;
    logic [14:0] pc;
  } ent_t;

  ent_t        mq[$];
  int          m_state;   // 0 boot, 1 fetch, 2 halt
  logic [14:0] m_pc;
  logic        h_cur;

  fetch_unit_if bus_if();

  fetch_unit #(.RESET_PC(15'h0000), .QDEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Program image at halfwords 0..7; elsewhere a pattern that cannot collide with it.
  function automatic logic [15:0] rom_word(input logic [14:0] a);
    case (a)
      15'd0: return 16'h2501;
      15'd1: return 16'h2601;
      15'd2: return 16'h2090;
      15'd3: return 16'h0600;
      15'd4: return 16'h2190;
      15'd5: return 16'h0609;
      15'd6: return 16'h1842;
      15'd7: return 16'h4175;
      default: return {1'b1, a};
    endcase
  endfunction

  function automatic logic [15:0] rom_next(input logic [14:0] a);
    logic [14:0] n;
    n = a + 15'd1;
    return rom_word(n);
  endfunction

  assign bus_if.IR_0 = rom_word({bus_if.Rom_addr_in, bus_if.pc_1});
  assign bus_if.IR_1 = rom_next({bus_if.Rom_addr_in, bus_if.pc_1});

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every observable output with the model.
  task automatic compare();
    int cnt;
    cnt = (mq.size() > 2) ? 2 : mq.size();
    chk("dec_count", 32'(bus_if.dec_count), 32'(cnt));
    chk("dec_instr_0", 32'(bus_if.dec_instr_0), (cnt >= 1) ? 32'(mq[0].instr) : 32'h0);
    chk("dec_instr_1", 32'(bus_if.dec_instr_1), (cnt == 2) ? 32'(mq[1].instr) : 32'h0);
    if (cnt >= 1) begin
      chk("dec_pc_0", 32'(bus_if.dec_pc_0), 32'(mq[0].pc));
    end
    chk("rom_addr", 32'(bus_if.Rom_addr_in), 32'(m_pc >> 1));
    chk("pc_1", 32'(bus_if.pc_1), 32'(m_pc % 2));
    chk("sel_mem_1", 32'(bus_if.sel_mem_1), (m_pc % 2 == 0) ? 32'd1 : 32'd0);
    chk("sel_mem_0", 32'(bus_if.sel_mem_0), (m_pc % 2 == 0) ? 32'd0 : 32'd2);
  endtask

  // One clock: drive inputs, advance the model, then sample after the edge.
  task automatic step(input logic r, input logic bv, input logic [14:0] bt,
                      input logic h, input logic [1:0] tk);
    int   avail, t;
    bit   fire;
    ent_t e;
    @(negedge clk);
    rst                  = r;
    bus_if.branch_valid  = bv;
    bus_if.branch_target = bt;
    bus_if.halt_req      = h;
    bus_if.dec_take      = tk;
    if (r) begin
      m_state = 0;
      m_pc    = 15'h0000;
      mq.delete();
    end else if (bv) begin
      mq.delete();
      m_pc    = bt;
      m_state = h ? 2 : 1;
    end else begin
      avail = (mq.size() > 2) ? 2 : mq.size();
      t     = (int'(tk) > avail) ? avail : int'(tk);
      fire  = (m_state == 1) && !h && (mq.size() <= 2);
      repeat (t) void'(mq.pop_front());
      if (fire) begin
        e.instr = rom_word(m_pc);
        e.pc    = m_pc;
        mq.push_back(e);
        e.pc    = m_pc + 15'd1;
        e.instr = rom_word(e.pc);
        mq.push_back(e);
        m_pc    = m_pc + 15'd2;
      end
      m_state = (m_state == 0) ? 1 : (h ? 2 : 1);
    end
    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    rst                  = 1'b1;
    bus_if.branch_valid  = 1'b0;
    bus_if.branch_target = 15'h0000;
    bus_if.halt_req      = 1'b0;
    bus_if.dec_take      = 2'd0;
    m_state              = 0;
    m_pc                 = 15'h0000;
    h_cur                = 1'b0;

    // Reset state
    step(1'b1, 1'b0, 15'h0, 1'b0, 2'd0);
    step(1'b1, 1'b0, 15'h0, 1'b0, 2'd0);
    chk("rst_count", 32'(bus_if.dec_count), 32'd0);
    chk("rst_pc0", 32'(bus_if.dec_pc_0), 32'h0);
    chk("rst_instr0", 32'(bus_if.dec_instr_0), 32'h0);

    // No consumption: first pair after 2 cycles, queue fills, ROM address holds
    step(1'b0, 1'b0, 15'h0, 1'b0, 2'd0);
    chk("boot_count", 32'(bus_if.dec_count), 32'd0);
    step(1'b0, 1'b0, 15'h0, 1'b0, 2'd0);
    chk("lat_count", 32'(bus_if.dec_count), 32'd2);
    chk("lat_i0", 32'(bus_if.dec_instr_0), 32'h2501);
    chk("lat_i1", 32'(bus_if.dec_instr_1), 32'h2601);
    step(1'b0, 1'b0, 15'h0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 15'h0, 1'b0, 2'd0);
    chk("full_rom_addr", 32'(bus_if.Rom_addr_in), 32'd2);
    chk("full_i0", 32'(bus_if.dec_instr_0), 32'h2501);

    // Steady take of 2
    step(1'b1, 1'b0, 15'h0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 15'h0, 1'b0, 2'd2);
    step(1'b0, 1'b0, 15'h0, 1'b0, 2'd2);
    chk("s_i0_a", 32'(bus_if.dec_instr_0), 32'h2501);
    chk("s_i1_a", 32'(bus_if.dec_instr_1), 32'h2601);
    step(1'b0, 1'b0, 15'h0, 1'b0, 2'd2);
    chk("s_i0_b", 32'(bus_if.dec_instr_0), 32'h2090);
    chk("s_i1_b", 32'(bus_if.dec_instr_1), 32'h0600);
    step(1'b0, 1'b0, 15'h0, 1'b0, 2'd2);
    chk("s_i0_c", 32'(bus_if.dec_instr_0), 32'h2190);
    chk("s_i1_c", 32'(bus_if.dec_instr_1), 32'h0609);
    step(1'b0, 1'b0, 15'h0, 1'b0, 2'd2);
    chk("s_i0_d", 32'(bus_if.dec_instr_0), 32'h1842);
    chk("s_i1_d", 32'(bus_if.dec_instr_1), 32'h4175);
    chk("s_sel0", 32'(bus_if.sel_mem_0), 32'd0);
    chk("s_sel1", 32'(bus_if.sel_mem_1), 32'd1);

    // Branch to odd halfword 3
    step(1'b0, 1'b1, 15'h0003, 1'b0, 2'd2);
    chk("br_count", 32'(bus_if.dec_count), 32'd0);
    chk("br_pc_1", 32'(bus_if.pc_1), 32'd1);
    chk("br_sel0", 32'(bus_if.sel_mem_0), 32'd2);
    chk("br_sel1", 32'(bus_if.sel_mem_1), 32'd0);
    chk("br_addr", 32'(bus_if.Rom_addr_in), 32'd1);
    step(1'b0, 1'b0, 15'h0, 1'b0, 2'd0);
    chk("br_i0", 32'(bus_if.dec_instr_0), 32'h0600);
    chk("br_i1", 32'(bus_if.dec_instr_1), 32'h2190);
    chk("br_pc0", 32'(bus_if.dec_pc_0), 32'h3);

    // PC wrap at the top of the address space
    step(1'b0, 1'b1, 15'h7FFF, 1'b0, 2'd0);
    step(1'b0, 1'b0, 15'h0, 1'b0, 2'd0);
    chk("wrap_pc0", 32'(bus_if.dec_pc_0), 32'h7FFF);
    chk("wrap_i1", 32'(bus_if.dec_instr_1), 32'h2501);
    chk("wrap_addr", 32'(bus_if.Rom_addr_in), 32'd0);
    chk("wrap_pc_1", 32'(bus_if.pc_1), 32'd1);

    // Halt drains the queue with the PC frozen, then resumes
    step(1'b1, 1'b0, 15'h0, 1'b0, 2'd0);
    repeat (4) step(1'b0, 1'b0, 15'h0, 1'b0, 2'd0);
    repeat (5) step(1'b0, 1'b0, 15'h0, 1'b1, 2'd1);
    chk("halt_count", 32'(bus_if.dec_count), 32'd0);
    chk("halt_addr", 32'(bus_if.Rom_addr_in), 32'd2);
    step(1'b0, 1'b0, 15'h0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 15'h0, 1'b0, 2'd0);
    chk("resume_i0", 32'(bus_if.dec_instr_0), 32'h2190);
    chk("resume_pc0", 32'(bus_if.dec_pc_0), 32'h4);

    // Reset pulse while halfwords 4/5 are being fetched
    step(1'b1, 1'b0, 15'h0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 15'h0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 15'h0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 15'h0, 1'b0, 2'd2);
    step(1'b1, 1'b1, 15'h0055, 1'b0, 2'd0);
    chk("rp_count", 32'(bus_if.dec_count), 32'd0);
    step(1'b0, 1'b0, 15'h0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 15'h0, 1'b0, 2'd0);
    chk("rp_i0", 32'(bus_if.dec_instr_0), 32'h2501);
    chk("rp_i1", 32'(bus_if.dec_instr_1), 32'h2601);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic        r, bv;
      logic [14:0] bt;
      logic [1:0]  tk;
      if ($urandom_range(7) == 0) h_cur = ~h_cur;
      r  = ($urandom_range(149) == 0);
      bv = ($urandom_range(11) == 0);
      bt = ($urandom_range(3) == 0) ? (15'h7FFF - 15'($urandom_range(1))) : 15'($urandom);
      tk = 2'($urandom_range(2));
      step(r, bv, bt, h_cur, tk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
